// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the FSM state encoding and the default operand width.
package seq_multiplier_pkg;

  localparam int unsigned mul_n = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier_adder.sv
// n-bit generate/propagate adder with carry-in and an n+1-bit result.
// This is the only adder in the multiplier datapath.
module carry_lookahead_adder #(
  parameter int n = 64
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n:0]   sum
);

  logic [n-1:0] g;
  logic [n-1:0] p;
  logic         carry;

  assign g = a & b;
  assign p = a ^ b;

  // Carry recurrence c[i+1] = g[i] | p[i]&c[i], unrolled over the word.
  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < n; i++) begin
      sum[i] = p[i] ^ carry;
      carry  = g[i] | (p[i] & carry);
    end
    sum[n] = carry;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned n x n -> 2n shift-add multiplier, one partial product per cycle.
// Handshake: a start is taken when start && in_ready at a rising edge; a result
// is handed off when out_valid && out_ready at a rising edge.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int n = mul_n
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           in_ready,
  input  logic [n-1:0]   X,
  input  logic [n-1:0]   Y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*n-1:0] product,
  output logic           busy,
  output state_t         dbg_state
);

  localparam int cw = $clog2(n + 1);
  localparam logic [cw-1:0] last_iter = cw'(n - 1);

  state_t        state;
  state_t        state_next;
  logic [n-1:0]  mcand;
  logic [n-1:0]  p_lo;
  logic [n:0]    p_hi;
  logic [cw-1:0] cnt;
  logic [n:0]    add_sum;
  logic [n:0]    sum;

  carry_lookahead_adder #(.n(n)) u_adder (
    .a   (p_hi[n-1:0]),
    .b   (mcand),
    .cin (1'b0),
    .sum (add_sum)
  );

  // p_hi[n] is always zero after a shift, so passing p_hi whole is {0, p_hi[n-1:0]}.
  assign sum = p_lo[0] ? add_sum : p_hi;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (cnt == last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      mcand <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= X;
            p_lo  <= Y;
            p_hi  <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          p_hi <= {1'b0, sum[n:1]};
          p_lo <= {sum[0], p_lo[n-1:1]};
          cnt  <= cnt + cw'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign product   = {p_hi[n-1:0], p_lo};
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed and random multiplies against a
// count-based behavioural model with an expected-product queue.
module tb_seq_multiplier;

  localparam int N = 64;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_ready;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] product;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  seq_multiplier #(.n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: edges remaining in the iteration, pending result, last result.
  logic [W-1:0] exp_q[$];
  int           m_left    = 0;
  bit           m_pending = 1'b0;
  logic [W-1:0] m_last    = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left    = 0;
      m_pending = 1'b0;
      m_last    = '0;
      exp_q.delete();
    end else if (m_pending) begin
      if (out_ready) begin
        m_last    = exp_q.pop_front();
        m_pending = 1'b0;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_pending = 1'b1;
    end else if (start) begin
      m_left = N;
      exp_q.push_back(W'(X) * W'(Y));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", W'(in_ready), W'(!m_pending && m_left == 0));
      chk("m_busy", W'(busy), W'(m_left > 0));
      chk("m_out_valid", W'(out_valid), W'(m_pending));
      if (m_pending) chk("m_product_done", product, exp_q[0]);
      else if (m_left == 0) chk("m_product_idle", product, m_last);
    end
  end

  // One multiply from IDLE; pulse_at/abort_at are busy-edge indices (-1 = none).
  task automatic run_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [W-1:0] lit, input int hold,
                         input int pulse_at, input int abort_at, input string tag);
    int edges;
    bit got;
    chk({tag, "_in_ready_before"}, W'(in_ready), W'(1));
    X = x;
    Y = y;
    start = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    got = 1'b0;
    while (edges < 200 && !got) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        X = {$urandom, $urandom};
        Y = {$urandom, $urandom};
        start = (edges == pulse_at);
        if (start) begin
          X = 2;
          Y = 2;
        end
        if (edges == abort_at) begin
          rst = 1'b1;
          start = 1'b1;
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          start = 1'b0;
          chk({tag, "_abort_in_ready"}, W'(in_ready), W'(1));
          chk({tag, "_abort_busy"}, W'(busy), W'(0));
          chk({tag, "_abort_out_valid"}, W'(out_valid), W'(0));
          chk({tag, "_abort_product"}, product, '0);
          return;
        end
      end
    end
    start = 1'b0;
    if (!got) begin
      chk({tag, "_timeout"}, W'(0), W'(1));
      return;
    end
    chk({tag, "_latency"}, W'(edges), W'(N));
    chk({tag, "_product"}, product, lit);
    out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, W'(out_valid), W'(1));
      chk({tag, "_hold_product"}, product, lit);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_after"}, W'(in_ready), W'(1));
    chk({tag, "_valid_after"}, W'(out_valid), W'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] x;
    logic [N-1:0] y;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    X = '0;
    Y = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_product", product, '0);
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_state", W'(dbg_state), W'(0));
    chk_en = 1'b1;

    run_mul(64'd3, 64'd5, 128'd15, 0, -1, -1, "basic");
    run_mul({N{1'b1}}, {N{1'b1}}, 128'hFFFFFFFFFFFFFFFE_0000000000000001, 1, -1, -1, "max");
    run_mul(64'd0, 64'hDEADBEEF, 128'd0, 0, -1, -1, "zero_x");
    run_mul(64'h1234, 64'd0, 128'd0, 0, -1, -1, "zero_y");
    run_mul(64'd7, 64'd9, 128'd63, 0, 10, -1, "pulse");
    run_mul(64'd6, 64'd7, 128'd42, 5, -1, -1, "stall");
    run_mul(64'd123, 64'd456, 128'd56088, 0, -1, 30, "abort");
    run_mul(64'd10, 64'd10, 128'd100, 0, -1, -1, "after_abort");

    for (int i = 0; i < 12; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (i % 4 == 1) x = 64'(1) << $urandom_range(0, 63);
      if (i % 4 == 2) y = {N{1'b1}};
      run_mul(x, y, W'(x) * W'(y), $urandom_range(0, 3), $urandom_range(1, 63),
              (i == 7) ? $urandom_range(1, 63) : -1, "rand");
    end

    @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter n, default 64, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port start  input  1  request to begin a multiply.
REQ-005 SHALL have port in_ready  output  1  high when a start will be accepted.
REQ-006 SHALL have port X  input  n  multiplicand, unsigned.
REQ-007 SHALL have port Y  input  n  multiplier, unsigned.
REQ-008 SHALL have port out_valid  output  1  product holds a finished result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port product  output  2n  unsigned X*Y.
REQ-011 SHALL have port busy  output  1  high while iterating.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 in_ready SHALL equal (state==IDLE); busy SHALL equal (state==BUSY); out_valid SHALL equal (state==DONE).
REQ-014 IDLE with start=1 at an edge: SHALL latch X into the multiplicand register, latch Y into P_lo, clear P_hi (n+1 bits) and the iteration counter, and go to BUSY.
REQ-015 start SHALL be ignored in BUSY and DONE; X and Y SHALL be ignored except at the accepting edge.
REQ-016 Each BUSY edge SHALL compute sum = P_lo[0] ? P_hi[n-1:0] + multiplicand (n+1-bit result from the shared adder) : {1'b0, P_hi[n-1:0]}, then set {P_hi, P_lo} = {sum, P_lo} >> 1 (P_hi[n] receives 0).
REQ-017 The iteration counter SHALL increment once per BUSY edge; width SHALL be clog2(n+1) bits, and it SHALL not wrap before reaching n.
REQ-018 On the BUSY edge where counter reaches n-1 (the nth iteration), the FSM SHALL go to DONE.
REQ-019 Latency: out_valid SHALL rise exactly n edges after the accepting edge, with a fixed count and no early termination for zero operands.
REQ-020 product SHALL equal {P_hi[n-1:0], P_lo}, be exact for all operands (no overflow, since 2n bits suffice), and stay stable throughout DONE.
REQ-021 DONE with out_ready=1 at an edge: SHALL go to IDLE; a new start SHALL be accepted no earlier than the following edge.
REQ-022 DONE with out_ready=0: SHALL hold state and product indefinitely.
REQ-023 out_ready outside DONE SHALL have no effect.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, clear the counter, P_hi, P_lo and the multiplicand, and drive product=0, out_valid=0, busy=0 and in_ready=1 after that edge.
REQ-025 rst SHALL take priority over start and out_ready, and SHALL abort an in-flight multiply from any state with no result produced.

Structure
REQ-026 A shared arithmetic package/include SHALL hold the state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the default width constant n=64.
REQ-027 The block SHALL instantiate exactly one carry_lookahead_adder (parameter n, carry-in 0, n+1-bit result) as its only sub-module, and all addition SHALL go through it.
REQ-028 Unused state encoding 2'd3 SHALL recover to IDLE at the next edge.

Verification
REQ-029 n=64, X=3, Y=5, start, out_ready=1 -> out_valid rises 64 edges after acceptance, product=15, IDLE one edge later.
REQ-030 X=Y=2^64-1 -> product=0xFFFFFFFFFFFFFFFE_0000000000000001.
REQ-031 X=0, Y=0xDEADBEEF, then X=0x1234, Y=0 -> product=0 both times, latency still 64 edges.
REQ-032 Accept X=7, Y=9; pulse start with X=2, Y=2 at BUSY cycle 10 -> pulse ignored, product=63.
REQ-033 out_ready held 0 for 5 cycles in DONE -> product stable at the result and out_valid high for all 5 cycles; accepted on first out_ready=1.
REQ-034 rst asserted at BUSY cycle 30 -> after that edge state IDLE, product=0, in_ready=1; the next multiply (X=10, Y=10) completes with product=100.
